// File: rtl/rr_arb8.sv
// rr_arb8 -- eight-way round-robin arbiter with a bounded hold time.
// One requester owns the shared resource at a time. An owner keeps the grant
// until it drops its request or has held it for MAX_HOLD cycles while someone
// else is waiting. The next winner is always the first requester at or after
// the rotating pointer, which sits one past the most recent winner.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld
);

   // Last value the hold counter can reach; reaching it arms forced rotation.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] gnt_idx_q, gnt_idx_d;
   logic       gnt_vld_q, gnt_vld_d;

   // Candidates for the next grant. The current owner is masked out: on a
   // release its request is already low, in IDLE there is no owner, and on a
   // timeout it must be skipped. One search therefore serves every case.
   logic [7:0] cand;
   logic [7:0] cand_rot;
   logic       win_found;
   logic [2:0] win_off;
   logic [2:0] win_idx;

   logic       owner_req;
   logic       hold_expired;

   assign cand = req & ~gnt_q;

   // Rotate the candidates so that position 0 is the current highest priority.
   for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign cand_rot[gi] = cand[ptr_q + 3'(gi)];
   end

   // Lowest set bit of the rotated vector is the winner's offset from ptr.
   always_comb begin
      win_found = 1'b0;
      win_off   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (cand_rot[k]) begin
            win_found = 1'b1;
            win_off   = 3'(k);
         end
      end
   end

   // Undo the rotation; wraps naturally in three bits.
   assign win_idx = ptr_q + win_off;

   assign owner_req    = req[gnt_idx_q];
   assign hold_expired = (hold_cnt_q == HOLD_LAST);

   // Next-state and next-output logic of the IDLE/OWN machine.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_vld_d  = gnt_vld_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = OWN;
               gnt_d      = 8'b0000_0001 << win_idx;
               gnt_idx_d  = win_idx;
               gnt_vld_d  = 1'b1;
               ptr_d      = win_idx + 3'd1;
               hold_cnt_d = 8'd0;
            end
         end

         OWN: begin
            if (!owner_req) begin
               // Release wins over a simultaneous timeout.
               if (win_found) begin
                  gnt_d      = 8'b0000_0001 << win_idx;
                  gnt_idx_d  = win_idx;
                  gnt_vld_d  = 1'b1;
                  ptr_d      = win_idx + 3'd1;
                  hold_cnt_d = 8'd0;
               end else begin
                  state_d    = IDLE;
                  gnt_d      = 8'd0;
                  gnt_idx_d  = 3'd0;
                  gnt_vld_d  = 1'b0;
                  hold_cnt_d = 8'd0;
               end
            end else if (hold_expired && win_found) begin
               // Forced rotation away from an owner that has held too long.
               gnt_d      = 8'b0000_0001 << win_idx;
               gnt_idx_d  = win_idx;
               gnt_vld_d  = 1'b1;
               ptr_d      = win_idx + 3'd1;
               hold_cnt_d = 8'd0;
            end else if (!hold_expired) begin
               // Keep holding; the counter saturates once expired.
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 3'd0;
         hold_cnt_q <= 8'd0;
         gnt_q      <= 8'd0;
         gnt_idx_q  <= 3'd0;
         gnt_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_vld_q  <= gnt_vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Testbench for rr_arb8 (MAX_HOLD = 4): directed vector table, hand-written
// reset sequence, and randomized traffic against a behavioural model.
module tb_rr_arb8;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arb8 #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   int m_owner;   // -1 when nobody owns the resource
   int m_ptr;
   int m_held;    // cycles the owner has held beyond the grant cycle

   function automatic int first_from(input logic [7:0] mask, input int start);
      for (int k = 0; k < 8; k++) begin
         if (mask[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   task automatic m_award(input int w);
      m_owner = w;
      m_ptr   = (w + 1) % 8;
      m_held  = 0;
   endtask

   task automatic m_step(input logic [7:0] r);
      int w;
      if (m_owner < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) m_award(w);
      end else if (!r[m_owner]) begin
         w = first_from(r, m_ptr);
         if (w >= 0) m_award(w);
         else begin
            m_owner = -1;
            m_held  = 0;
         end
      end else begin
         logic [7:0] others;
         others = r;
         others[m_owner] = 1'b0;
         if (m_held == MH - 1 && others != 8'd0) m_award(first_from(others, m_ptr));
         else if (m_held < MH - 1) m_held++;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input bit exp_vld, input int exp_idx);
      logic [7:0] exp_gnt;
      exp_gnt = exp_vld ? (8'b1 << exp_idx) : 8'd0;
      $display("t=%0t %s req=%h gnt=%h idx=%0d vld=%0b", $time, name, req, gnt, gnt_idx, gnt_vld);
      chk({name, "_gnt"},     32'(gnt),     32'(exp_gnt));
      chk({name, "_gnt_idx"}, 32'(gnt_idx), exp_vld ? 32'(exp_idx) : 32'd0);
      chk({name, "_gnt_vld"}, 32'(gnt_vld), 32'(exp_vld));
   endtask

   // Apply a request vector, clock once, settle just past the edge.
   task automatic cyc(input logic [7:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed away from the rising edge.
   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_out("rst_pulse", 1'b0, 0);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         do_rst;
      logic [7:0] req;
      bit         vld;
      int         idx;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input logic [7:0] q, input bit v, input int i);
      vec_t e;
      e.do_rst = r; e.req = q; e.vld = v; e.idx = i;
      tbl.push_back(e);
   endtask

   initial begin
      logic [7:0] rr;
      int sel;

      rst = 1'b1;
      req = 8'd0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset_state", 1'b0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 0);
      // Full request set, each owner dropping after one cycle: 0..7 then wrap.
      add(1'b0, 8'hFF, 1'b1, 0);
      for (int i = 1; i <= 8; i++) add(1'b0, 8'hFF & ~(8'b1 << ((i - 1) % 8)), 1'b1, i % 8);
      add(1'b0, 8'h00, 1'b0, 0);
      // Timeout rotation between two requesters.
      add(1'b1, 8'h05, 1'b1, 0);
      for (int i = 0; i < 3; i++) add(1'b0, 8'h05, 1'b1, 0);
      for (int i = 0; i < 4; i++) add(1'b0, 8'h05, 1'b1, 2);
      add(1'b0, 8'h05, 1'b1, 0);
      // Lone requester holds past timeout; newcomer wins on the next edge.
      add(1'b1, 8'h08, 1'b1, 3);
      for (int i = 0; i < 9; i++) add(1'b0, 8'h08, 1'b1, 3);
      add(1'b0, 8'h0A, 1'b1, 1);
      // Release to idle, then pointer-based search from 6.
      add(1'b1, 8'h20, 1'b1, 5);
      add(1'b0, 8'h00, 1'b0, 0);
      add(1'b0, 8'h41, 1'b1, 6);
      // Release coinciding with timeout and no other requester goes idle.
      add(1'b1, 8'h01, 1'b1, 0);
      for (int i = 0; i < 5; i++) add(1'b0, 8'h01, 1'b1, 0);
      add(1'b0, 8'h00, 1'b0, 0);

      foreach (tbl[n]) begin
         if (tbl[n].do_rst) reset_pulse();
         cyc(tbl[n].req);
         chk_out($sformatf("vec%0d", n), tbl[n].vld, tbl[n].idx);
      end

      // Reset in the middle of a grant drops it before the next edge.
      reset_pulse();
      cyc(8'h10);
      chk_out("mid_rst_grant", 1'b1, 4);
      #2;
      rst = 1'b1;
      #1;
      chk_out("mid_rst_immediate", 1'b0, 0);
      @(posedge clk);
      #1;
      chk_out("mid_rst_held", 1'b0, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(8'h30);
      chk_out("after_rst_ptr0", 1'b1, 4);

      // Randomized traffic against the model.
      reset_pulse();
      rr = 8'd0;
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 19));
         if (sel == 19) begin
            reset_pulse();
         end
         case (sel % 10)
            0, 1, 2: ;
            3, 4:    rr = rr ^ (8'b1 << $urandom_range(0, 7));
            5:       rr = 8'($urandom);
            6:       rr = 8'd0;
            7, 8:    if (m_owner >= 0) rr[m_owner] = 1'b0;
            default: rr = 8'b1 << $urandom_range(0, 7);
         endcase
         cyc(rr);
         m_step(rr);
         chk_out($sformatf("rand%0d", n), m_owner >= 0, (m_owner >= 0) ? m_owner : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
